hack_rom_loader: RTL and testbench

- Boot-time program loader for the Hack Computer. It receives a Hack program as a byte stream over a valid/ready interface and writes it word by word into the instruction ROM.
- It holds the CPU in reset until the whole image has been written and its checksum verified.
- It sits between an external byte source (UART or test driver) and the Computer's ROM write port and reset input.

---
 rtl/hack_rom_loader_pkg.sv | 31 +++
 rtl/hack_word_assembler.sv | 48 ++++
 rtl/hack_rom_loader.sv | 150 +++++++++++++++
 tb/tb_hack_rom_loader.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/hack_rom_loader_pkg.sv
// Shared types and constants for the Hack boot loader: FSM encoding, field widths
// and the checksum/state helper functions.
package hack_rom_loader_pkg;

  localparam int HACK_WORD_W = 16;
  localparam int BYTE_W      = 8;
  localparam int LEN_W       = 16;
  localparam int CSUM_W      = 8;

  typedef enum logic [2:0] {
    ST_LEN_HI  = 3'd0,
    ST_LEN_LO  = 3'd1,
    ST_DATA_HI = 3'd2,
    ST_DATA_LO = 3'd3,
    ST_CSUM    = 3'd4,
    ST_RUN     = 3'd5,
    ST_ERR     = 3'd6
  } state_t;

  // Running frame checksum: 8-bit sum, carry discarded.
  function automatic logic [CSUM_W-1:0] csum_add(input logic [CSUM_W-1:0] acc,
                                                 input logic [BYTE_W-1:0] b);
    return acc + b;
  endfunction

  function automatic logic is_rx_state(input state_t s);
    return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DATA_HI) ||
           (s == ST_DATA_LO) || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/hack_word_assembler.sv
// Joins hi/lo bytes into a Hack word, emits a one-cycle write strobe and keeps
// the running checksum of all data bytes.
module hack_word_assembler
  import hack_rom_loader_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   hi_en,
  input  logic                   lo_en,
  input  logic [BYTE_W-1:0]      data,
  output logic                   we,
  output logic [HACK_WORD_W-1:0] wdata,
  output logic [CSUM_W-1:0]      csum
);

  logic [BYTE_W-1:0]      hi_r;
  logic [HACK_WORD_W-1:0] wdata_r;
  logic [CSUM_W-1:0]      csum_r;
  logic                   we_r;

  // Byte latch, word join, strobe and checksum accumulation.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hi_r    <= {BYTE_W{1'b0}};
      wdata_r <= {HACK_WORD_W{1'b0}};
      csum_r  <= {CSUM_W{1'b0}};
      we_r    <= 1'b0;
    end else begin
      we_r <= lo_en;
      if (clear) begin
        hi_r   <= {BYTE_W{1'b0}};
        csum_r <= {CSUM_W{1'b0}};
      end else if (hi_en) begin
        hi_r   <= data;
        csum_r <= csum_add(csum_r, data);
      end else if (lo_en) begin
        wdata_r <= {hi_r, data};
        csum_r  <= csum_add(csum_r, data);
      end
    end
  end

  assign we    = we_r;
  assign wdata = wdata_r;
  assign csum  = csum_r;

endmodule

// File: rtl/hack_rom_loader.sv
// Boot loader: parses a length/data/checksum byte frame, writes words into the
// Hack ROM and releases the CPU from reset only once the image is verified.
module hack_rom_loader
  import hack_rom_loader_pkg::*;
#(
  parameter int ADDR_W    = 15,
  parameter int MAX_WORDS = 32768
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [BYTE_W-1:0]      in_data,
  output logic                   in_ready,
  input  logic                   reload,
  output logic                   rom_we,
  output logic [ADDR_W-1:0]      rom_addr,
  output logic [HACK_WORD_W-1:0] rom_wdata,
  output logic                   cpu_reset,
  output logic                   done,
  output logic                   error
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int CMP_W = (ADDR_W + 2 > LEN_W + 1) ? ADDR_W + 2 : LEN_W + 1;

  state_t              state_r, state_next_s;
  logic [LEN_W-1:0]    len_r, len_s;
  logic [CNT_W-1:0]    word_cnt_r;
  logic [CMP_W-1:0]    next_cnt_s;
  logic [ADDR_W-1:0]   addr_r;
  logic                in_ready_r, cpu_reset_r, done_r, error_r;
  logic                xfer_s, hi_en_s, lo_en_s, clear_s, rom_we_s;
  logic [CSUM_W-1:0]   csum_s;

  assign xfer_s     = in_valid && in_ready_r;
  assign len_s      = {len_r[LEN_W-1:BYTE_W], in_data};
  assign next_cnt_s = CMP_W'(word_cnt_r) + CMP_W'(1);

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_r <= ST_LEN_HI;
    else        state_r <= state_next_s;
  end

  // Next-state decode and byte routing into the assembler.
  always_comb begin
    state_next_s = state_r;
    hi_en_s      = 1'b0;
    lo_en_s      = 1'b0;
    clear_s      = 1'b0;
    case (state_r)
      ST_LEN_HI: begin
        if (xfer_s) state_next_s = ST_LEN_LO;
        else        state_next_s = state_r;
      end
      ST_LEN_LO: begin
        if (xfer_s) begin
          if (CMP_W'(len_s) > CMP_W'(MAX_WORDS)) state_next_s = ST_ERR;
          else if (len_s == {LEN_W{1'b0}})       state_next_s = ST_CSUM;
          else                                   state_next_s = ST_DATA_HI;
        end else begin
          state_next_s = state_r;
        end
      end
      ST_DATA_HI: begin
        hi_en_s = xfer_s;
        if (xfer_s) state_next_s = ST_DATA_LO;
        else        state_next_s = state_r;
      end
      ST_DATA_LO: begin
        lo_en_s = xfer_s;
        // word_cnt_r still holds this word's index; it advances one edge later
        if (xfer_s) begin
          if (next_cnt_s == CMP_W'(len_r)) state_next_s = ST_CSUM;
          else                             state_next_s = ST_DATA_HI;
        end else begin
          state_next_s = state_r;
        end
      end
      ST_CSUM: begin
        if (xfer_s) begin
          if (in_data == csum_s) state_next_s = ST_RUN;
          else                   state_next_s = ST_ERR;
        end else begin
          state_next_s = state_r;
        end
      end
      ST_RUN: begin
        if (reload) begin
          state_next_s = ST_LEN_HI;
          clear_s      = 1'b1;
        end else begin
          state_next_s = state_r;
        end
      end
      ST_ERR:  state_next_s = ST_ERR;
      default: state_next_s = ST_ERR;
    endcase
  end

  // Length capture, word index and ROM address.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      len_r      <= {LEN_W{1'b0}};
      word_cnt_r <= {CNT_W{1'b0}};
      addr_r     <= {ADDR_W{1'b0}};
    end else begin
      if (clear_s)       word_cnt_r <= {CNT_W{1'b0}};
      else if (rom_we_s) word_cnt_r <= word_cnt_r + CNT_W'(1);
      if (xfer_s && (state_r == ST_LEN_HI)) len_r[LEN_W-1:BYTE_W] <= in_data;
      if (xfer_s && (state_r == ST_LEN_LO)) len_r[BYTE_W-1:0]     <= in_data;
      if (lo_en_s) addr_r <= word_cnt_r[ADDR_W-1:0];
    end
  end

  // Status outputs registered from the next state so they track it exactly.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      in_ready_r  <= 1'b0;
      cpu_reset_r <= 1'b1;
      done_r      <= 1'b0;
      error_r     <= 1'b0;
    end else begin
      in_ready_r  <= is_rx_state(state_next_s);
      cpu_reset_r <= (state_next_s != ST_RUN);
      done_r      <= (state_next_s == ST_RUN);
      error_r     <= (state_next_s == ST_ERR);
    end
  end

  hack_word_assembler u_asm (
    .clock (clock),
    .reset (reset),
    .clear (clear_s),
    .hi_en (hi_en_s),
    .lo_en (lo_en_s),
    .data  (in_data),
    .we    (rom_we_s),
    .wdata (rom_wdata),
    .csum  (csum_s)
  );

  assign in_ready  = in_ready_r;
  assign rom_we    = rom_we_s;
  assign rom_addr  = addr_r;
  assign cpu_reset = cpu_reset_r;
  assign done      = done_r;
  assign error     = error_r;

endmodule

// File: tb/tb_hack_rom_loader.sv
// Randomized bench for hack_rom_loader: byte frames are checked against a
// frame-level reference model and a write scoreboard.
module tb_hack_rom_loader;

  typedef logic [7:0]  bq_t[$];
  typedef logic [30:0] wq_t[$];

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, v2 = 1'b0, reload = 1'b0, reload2 = 1'b0;
  logic [7:0]  in_data = 8'h00, d2 = 8'h00;
  logic        in_ready, rom_we, cpu_reset, done, error;
  logic [14:0] rom_addr;
  logic [15:0] rom_wdata;
  logic        in_ready2, rom_we2, cpu_reset2, done2, error2;
  logic [14:0] rom_addr2;
  logic [15:0] rom_wdata2;

  int n_checks = 0;
  int n_fail   = 0;
  wq_t got0, got1;

  always #5 clk = ~clk;

  hack_rom_loader dut (
    .clock(clk), .reset(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .reload(reload), .rom_we(rom_we), .rom_addr(rom_addr),
    .rom_wdata(rom_wdata), .cpu_reset(cpu_reset), .done(done), .error(error)
  );

  hack_rom_loader #(.ADDR_W(15), .MAX_WORDS(4)) dut_small (
    .clock(clk), .reset(rst_n), .in_valid(v2), .in_data(d2),
    .in_ready(in_ready2), .reload(reload2), .rom_we(rom_we2), .rom_addr(rom_addr2),
    .rom_wdata(rom_wdata2), .cpu_reset(cpu_reset2), .done(done2), .error(error2)
  );

  // Record every ROM write of both loaders.
  always @(negedge clk) begin
    if (rom_we)  got0.push_back({rom_addr, rom_wdata});
    if (rom_we2) got1.push_back({rom_addr2, rom_wdata2});
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic rdy(input int sel);
    return (sel == 0) ? in_ready : in_ready2;
  endfunction

  // Frame-level model: walks the byte list by the frame rules.
  // status: 0 incomplete, 1 run, 2 error; used = bytes the loader will consume.
  task automatic model(input bq_t fr, input int maxw, output int used,
                       output int status, output wq_t ew);
    int n, sum;
    ew.delete();
    status = 0;
    sum = 0;
    used = fr.size();
    if (fr.size() < 2) return;
    n = int'(fr[0]) * 256 + int'(fr[1]);
    used = 2;
    if (n > maxw) begin status = 2; return; end
    for (int w = 0; w < n; w++) begin
      if (used + 2 > fr.size()) begin used = fr.size(); return; end
      ew.push_back({w[14:0], fr[used], fr[used+1]});
      sum = (sum + int'(fr[used]) + int'(fr[used+1])) % 256;
      used += 2;
    end
    if (used >= fr.size()) return;
    status = (int'(fr[used]) == sum) ? 1 : 2;
    used++;
  endtask

  task automatic send_byte(input int sel, input logic [7:0] b, input int gap);
    int n;
    repeat (gap) @(negedge clk);
    if (sel == 0) begin in_valid = 1'b1; in_data = b; end
    else          begin v2 = 1'b1; d2 = b; end
    n = 0;
    while (!rdy(sel) && n < 50) begin @(negedge clk); n++; end
    if (!rdy(sel)) check_eq("ready_timeout", {31'd0, rdy(sel)}, 32'd1);
    else           @(negedge clk);
    in_valid = 1'b0;
    v2 = 1'b0;
  endtask

  task automatic run_frame(input int sel, input bq_t fr, input int maxgap, input string tag);
    int used, status, ng;
    wq_t ew, got;
    model(fr, (sel == 0) ? 32768 : 4, used, status, ew);
    if (sel == 0) got0.delete(); else got1.delete();
    for (int i = 0; i < used; i++)
      send_byte(sel, fr[i], (maxgap > 0) ? $urandom_range(0, maxgap) : 0);
    repeat (2) @(negedge clk);
    got = (sel == 0) ? got0 : got1;
    ng = got.size();
    check_eq({tag, "_nwr"}, ng, ew.size());
    for (int i = 0; i < ew.size(); i++)
      if (i < ng) check_eq({tag, "_wr"}, {1'b0, got[i]}, {1'b0, ew[i]});
    if (sel == 0) begin
      check_eq({tag, "_done"},  {31'd0, done},      {31'd0, status == 1});
      check_eq({tag, "_error"}, {31'd0, error},     {31'd0, status == 2});
      check_eq({tag, "_cpurst"},{31'd0, cpu_reset}, {31'd0, status != 1});
      check_eq({tag, "_ready"}, {31'd0, in_ready},  {31'd0, status == 0});
    end else begin
      check_eq({tag, "_done"},  {31'd0, done2},      {31'd0, status == 1});
      check_eq({tag, "_error"}, {31'd0, error2},     {31'd0, status == 2});
      check_eq({tag, "_cpurst"},{31'd0, cpu_reset2}, {31'd0, status != 1});
      check_eq({tag, "_ready"}, {31'd0, in_ready2},  {31'd0, status == 0});
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ready"},  {31'd0, in_ready},  32'd0);
    check_eq({tag, "_we"},     {31'd0, rom_we},    32'd0);
    check_eq({tag, "_addr"},   {17'd0, rom_addr},  32'd0);
    check_eq({tag, "_wdata"},  {16'd0, rom_wdata}, 32'd0);
    check_eq({tag, "_cpurst"}, {31'd0, cpu_reset}, 32'd1);
    check_eq({tag, "_done"},   {31'd0, done},      32'd0);
    check_eq({tag, "_error"},  {31'd0, error},     32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t f1, f2, fr;
    int nb, n, kind, sum;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;

    f1 = '{8'h00, 8'h02, 8'h00, 8'h02, 8'hEC, 8'h10, 8'hFE};
    run_frame(0, f1, 0, "t1");

    pulse_reset();
    f2 = '{8'h00, 8'h02, 8'h00, 8'h02, 8'hEC, 8'h10, 8'hFF};
    run_frame(0, f2, 0, "t2");
    nb = got0.size();
    in_valid = 1'b1;
    in_data  = 8'h00;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("t2_idle_nwr", got0.size(), nb);
    check_eq("t2_idle_err", {31'd0, error}, 32'd1);
    check_eq("t2_idle_rdy", {31'd0, in_ready}, 32'd0);

    pulse_reset();
    run_frame(0, '{8'h00, 8'h00, 8'h00}, 0, "t3");

    pulse_reset();
    run_frame(1, '{8'h00, 8'h05}, 2, "t4");
    check_eq("t4_never_we", got1.size(), 0);
    pulse_reset();
    fr = '{8'h00, 8'h04};
    sum = 0;
    for (int i = 0; i < 8; i++) begin
      fr.push_back(8'($urandom));
      sum = (sum + int'(fr[fr.size()-1])) % 256;
    end
    fr.push_back(8'(sum));
    run_frame(1, fr, 2, "t4_max");

    pulse_reset();
    run_frame(0, f1, 5, "t5");
    @(negedge clk);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    check_eq("t5_rl_cpurst", {31'd0, cpu_reset}, 32'd1);
    check_eq("t5_rl_done",   {31'd0, done},      32'd0);
    check_eq("t5_rl_ready",  {31'd0, in_ready},  32'd1);
    run_frame(0, '{8'h00, 8'h01, 8'h12, 8'h34, 8'h46}, 0, "t5b");

    pulse_reset();
    for (int i = 0; i < 5; i++) send_byte(0, f1[i], 0);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("t6");
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(0, f1, 0, "t6b");

    for (int it = 0; it < 6; it++) begin
      pulse_reset();
      kind = $urandom_range(0, 3);
      if (kind == 0) begin
        fr = '{8'h80, 8'h01};
      end else begin
        n = $urandom_range(1, 6);
        fr = '{8'h00, 8'(n)};
        sum = 0;
        for (int i = 0; i < 2 * n; i++) begin
          fr.push_back(8'($urandom));
          sum = (sum + int'(fr[fr.size()-1])) % 256;
        end
        if (kind == 1) sum = (sum + 1) % 256;
        fr.push_back(8'(sum));
      end
      run_frame(0, fr, 3, "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
